oled_spi_ctrl: RTL and testbench
================================

OLED_SPI_CTRL -- requirements
Module: oled_spi_ctrl

Interface
REQ-001 SHALL provide parameter STARTUP_WAIT, default 32'd10000000: clk cycles per power-sequence phase; 3*STARTUP_WAIT must fit in 32 bits.
REQ-002 SHALL provide parameter CLK_DIV, default 1 (range 1..255): clk cycles per ioSclk half-period.
REQ-003 SHALL provide parameter COLS, default 128: display columns.
REQ-004 SHALL provide parameter PAGES, default 8: display pages of 8 rows.
REQ-005 SHALL provide parameter CONTRAST, default 8'h7F: contrast byte sent at init.
REQ-006 SHALL provide parameter CMD_MAX, default 4: maximum user commands accepted per frame boundary.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_btn  in  1  reset; asynchronous, active-low.
- ioSclk  out  1  SPI clock.
- ioSdin  out  1  SPI data, MSB first.
- ioCs  out  1  chip select, active-low.
- ioDc  out  1  0 = command byte, 1 = data byte.
- ioReset  out  1  panel reset, active-low.
- pixelAddress  out  AW = $clog2(COLS*PAGES)  framebuffer byte index.
- pixelData  in  8  framebuffer byte at pixelAddress.
- cmd_valid  in  1  user command byte pending.
- cmd_data  in  8  user command byte.
- cmd_ready  out  1  user command accepted this cycle.
- frame_done  out  1  one-cycle pulse after the last data byte of a frame.
- busy  out  1  high until the init sequence completes.

Function
REQ-008 States SHALL be: POWER, INIT_LOAD, WIN_LOAD, DATA_LOAD, CMD_CHECK, SEND, GAP.
REQ-009 POWER: ioReset=1 for counter < STARTUP_WAIT, 0 for counter < 2*STARTUP_WAIT, 1 for counter < 3*STARTUP_WAIT; then counter clears and the state moves to INIT_LOAD.
REQ-010 Init table, 23 bytes in this order, all sent with ioDc=0: AE, 81, CONTRAST, A6, 20, 00, C8, 40, A1, A8, PAGES*8-1, D3, 00, D5, 80, D9, 22, DB, 20, 8D, 14, A4, AF.
REQ-011 Each LOAD state SHALL last 1 cycle: it latches the byte and ioDc, sets ioCs=0 and enters SEND.
REQ-012 SEND, per bit from 7 down to 0:
- ioSclk=0 and ioSdin=bit for CLK_DIV cycles;
- then ioSclk=1 for CLK_DIV cycles;
- total 16*CLK_DIV cycles; then enter GAP.
REQ-013 GAP SHALL last 1 cycle with ioCs=1 and ioSclk=1; byte period = 16*CLK_DIV+2 cycles.
REQ-014 After GAP, the next state SHALL be: the next init byte; after the last init byte, WIN_LOAD with busy falling.
REQ-015 Each frame SHALL start with 6 window command bytes (ioDc=0): 21, 00, COLS-1, 22, 00, PAGES-1.
REQ-016 After the window bytes, DATA_LOAD SHALL send COLS*PAGES bytes with ioDc=1; byte k latches pixelData while pixelAddress=k.
REQ-017 pixelAddress SHALL be stable for at least 1 cycle before DATA_LOAD samples it, supporting 1-cycle-latency synchronous memory.
REQ-018 pixelAddress SHALL increment in the GAP after each data byte.
REQ-019 At the last data byte, pixelAddress SHALL wrap to 0, frame_done SHALL pulse in that GAP cycle, and the state SHALL move to CMD_CHECK.
REQ-020 CMD_CHECK: if cmd_valid=1 and fewer than CMD_MAX commands have been taken this boundary:
- cmd_ready=1 for that one cycle;
- cmd_data is latched and sent with ioDc=0;
- after its GAP, return to CMD_CHECK.
REQ-021 CMD_CHECK otherwise: go to WIN_LOAD, and clear the per-boundary command count.
REQ-022 cmd_ready SHALL be 0 in every state other than CMD_CHECK; cmd_valid outside CMD_CHECK SHALL be ignored, with no loss or duplication.
REQ-023 If cmd_valid rises in the same cycle as frame_done, it SHALL be accepted at the following CMD_CHECK.
REQ-024 Counters:
- startup counter 32 bits;
- bit counter 3 bits;
- divider counter 8 bits;
- init index 5 bits;
- window index 3 bits;
- pixel index AW bits, wrapping modulo COLS*PAGES.

Reset
REQ-025 rst_btn=0 SHALL force, asynchronously, state POWER, all counters 0, and outputs: ioReset=1, ioCs=1, ioSclk=1, ioSdin=0, ioDc=1, pixelAddress=0, cmd_ready=0, frame_done=0, busy=1.
REQ-026 Reset asserted mid-byte or mid-frame SHALL abort the transfer; after release, the full power and init sequence SHALL be repeated.

Verification (STARTUP_WAIT=4, CLK_DIV=1, COLS=4, PAGES=2 unless stated)
REQ-027 Power-up: release reset -> ioReset is 1 for cycles 0-3, 0 for cycles 4-7, 1 from cycle 8; first ioCs fall at cycle 13.
REQ-028 Init decode: an SPI monitor sampling on ioSclk rising -> 23 command bytes with ioDc=0, byte 3 = 7F, byte 11 = 0F; then 21,00,03,22,00,01; busy falls after the AF byte.
REQ-029 Frame data: framebuffer memory with 1-cycle latency holding 8'h10+k -> data bytes 10..17 in order with ioDc=1; frame_done pulses once; the second frame repeats the window bytes and 10..17.
REQ-030 Commands: hold cmd_valid=1 with cmd_data=A7 across a frame end, CMD_MAX=2 -> exactly 2 A7 bytes sent, each with a 1-cycle cmd_ready; the window follows; 2 more A7 after the next frame.
REQ-031 CLK_DIV=3: ioSclk low and high phases are 3 cycles each; byte period is 50 cycles.
REQ-032 Reset mid-frame: pull rst_btn low during data byte 5 -> outputs reach their reset values in the same cycle with no clk edge; after release, POWER restarts and pixelAddress=0.

Source files
------------

// File: rtl/oled_spi_ctrl.sv
`default_nettype none
// oled_spi_ctrl: SSD1306-style OLED SPI controller with power sequencing, init table,
// framebuffer streaming and per-frame user command insertion.  Rev 1.0
module oled_spi_ctrl #(
   parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
   parameter int unsigned CLK_DIV      = 1,
   parameter int unsigned COLS         = 128,
   parameter int unsigned PAGES        = 8,
   parameter logic [7:0]  CONTRAST     = 8'h7F,
   parameter int unsigned CMD_MAX      = 4,
   localparam int unsigned AW          = $clog2(COLS * PAGES)
) (
   input  logic          clk,
   input  logic          rst_btn,
   output logic          ioSclk,
   output logic          ioSdin,
   output logic          ioCs,
   output logic          ioDc,
   output logic          ioReset,
   output logic [AW-1:0] pixelAddress,
   input  logic [7:0]    pixelData,
   input  logic          cmd_valid,
   input  logic [7:0]    cmd_data,
   output logic          cmd_ready,
   output logic          frame_done,
   output logic          busy
);

   localparam logic [31:0]   PHASE2     = 2 * STARTUP_WAIT;
   localparam logic [31:0]   POWER_LAST = 3 * STARTUP_WAIT - 32'd1;
   localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [AW-1:0] PIX_LAST   = AW'(COLS * PAGES - 1);
   localparam logic [7:0]    COL_LAST   = 8'(COLS - 1);
   localparam logic [7:0]    PAGE_LAST  = 8'(PAGES - 1);
   localparam logic [7:0]    MUX_RATIO  = 8'(PAGES * 8 - 1);
   localparam logic [7:0]    CMD_LIMIT  = 8'(CMD_MAX);

   typedef enum logic [2:0] {
      POWER, INIT_LOAD, WIN_LOAD, DATA_LOAD, CMD_CHECK, SEND, GAP
   } state_t;

   typedef enum logic [1:0] {SRC_INIT, SRC_WIN, SRC_DATA, SRC_CMD} src_t;

   state_t        state_q, state_d;
   src_t          src_q, src_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    div_q, div_d;
   logic [4:0]    init_idx_q, init_idx_d;
   logic [2:0]    win_idx_q, win_idx_d;
   logic [AW-1:0] pix_q, pix_d;
   logic [7:0]    cmd_cnt_q, cmd_cnt_d;
   logic [6:0]    shift_q, shift_d;
   logic          sclk_q, sclk_d, sdin_q, sdin_d, cs_q, cs_d, dc_q, dc_d;
   logic          prst_q, prst_d, frame_done_q, frame_done_d, busy_q, busy_d;
   logic          load;
   logic [7:0]    load_byte, init_byte, win_byte;
   logic          load_dc;

   always_comb begin
      case (init_idx_q)
         5'd0:    init_byte = 8'hAE;
         5'd1:    init_byte = 8'h81;
         5'd2:    init_byte = CONTRAST;
         5'd3:    init_byte = 8'hA6;
         5'd4:    init_byte = 8'h20;
         5'd5:    init_byte = 8'h00;
         5'd6:    init_byte = 8'hC8;
         5'd7:    init_byte = 8'h40;
         5'd8:    init_byte = 8'hA1;
         5'd9:    init_byte = 8'hA8;
         5'd10:   init_byte = MUX_RATIO;
         5'd11:   init_byte = 8'hD3;
         5'd12:   init_byte = 8'h00;
         5'd13:   init_byte = 8'hD5;
         5'd14:   init_byte = 8'h80;
         5'd15:   init_byte = 8'hD9;
         5'd16:   init_byte = 8'h22;
         5'd17:   init_byte = 8'hDB;
         5'd18:   init_byte = 8'h20;
         5'd19:   init_byte = 8'h8D;
         5'd20:   init_byte = 8'h14;
         5'd21:   init_byte = 8'hA4;
         default: init_byte = 8'hAF;
      endcase
      case (win_idx_q)
         3'd0:    win_byte = 8'h21;
         3'd1:    win_byte = 8'h00;
         3'd2:    win_byte = COL_LAST;
         3'd3:    win_byte = 8'h22;
         3'd4:    win_byte = 8'h00;
         default: win_byte = PAGE_LAST;
      endcase
   end

   assign cmd_ready = (state_q == CMD_CHECK) && cmd_valid && (cmd_cnt_q < CMD_LIMIT);

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      div_d        = div_q;
      init_idx_d   = init_idx_q;
      win_idx_d    = win_idx_q;
      pix_d        = pix_q;
      cmd_cnt_d    = cmd_cnt_q;
      shift_d      = shift_q;
      sclk_d       = sclk_q;
      sdin_d       = sdin_q;
      cs_d         = cs_q;
      dc_d         = dc_q;
      prst_d       = prst_q;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      load         = 1'b0;
      load_byte    = 8'h00;
      load_dc      = 1'b0;

      case (state_q)
         POWER: begin
            if (cnt_q == POWER_LAST) begin
               cnt_d   = 32'd0;
               prst_d  = 1'b1;
               state_d = INIT_LOAD;
            end else begin
               cnt_d  = cnt_q + 32'd1;
               prst_d = (cnt_d < STARTUP_WAIT) || (cnt_d >= PHASE2);
            end
         end
         INIT_LOAD: begin
            load = 1'b1; load_byte = init_byte; src_d = SRC_INIT;
         end
         WIN_LOAD: begin
            load = 1'b1; load_byte = win_byte; src_d = SRC_WIN;
         end
         DATA_LOAD: begin
            load = 1'b1; load_byte = pixelData; load_dc = 1'b1; src_d = SRC_DATA;
         end
         CMD_CHECK: begin
            if (cmd_ready) begin
               load      = 1'b1;
               load_byte = cmd_data;
               src_d     = SRC_CMD;
               cmd_cnt_d = cmd_cnt_q + 8'd1;
            end else begin
               cmd_cnt_d = 8'd0;
               state_d   = WIN_LOAD;
            end
         end
         SEND: begin
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_q == 3'd0) begin
                  state_d = GAP;
                  cs_d    = 1'b1;
                  // Advance the address on GAP entry so 1-cycle-latency memory is ready by DATA_LOAD.
                  if (src_q == SRC_DATA) begin
                     pix_d        = (pix_q == PIX_LAST) ? '0 : pix_q + AW'(1);
                     frame_done_d = (pix_q == PIX_LAST);
                  end
               end else begin
                  bit_d   = bit_q - 3'd1;
                  sclk_d  = 1'b0;
                  sdin_d  = shift_q[6];
                  shift_d = {shift_q[5:0], 1'b0};
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         GAP: begin
            case (src_q)
               SRC_INIT: begin
                  if (init_idx_q == 5'd22) begin
                     init_idx_d = 5'd0;
                     busy_d     = 1'b0;
                     state_d    = WIN_LOAD;
                  end else begin
                     init_idx_d = init_idx_q + 5'd1;
                     state_d    = INIT_LOAD;
                  end
               end
               SRC_WIN: begin
                  if (win_idx_q == 3'd5) begin
                     win_idx_d = 3'd0;
                     state_d   = DATA_LOAD;
                  end else begin
                     win_idx_d = win_idx_q + 3'd1;
                     state_d   = WIN_LOAD;
                  end
               end
               SRC_DATA: state_d = frame_done_q ? CMD_CHECK : DATA_LOAD;
               default:  state_d = CMD_CHECK;
            endcase
         end
         default: state_d = POWER;
      endcase

      if (load) begin
         state_d = SEND;
         shift_d = load_byte[6:0];
         sdin_d  = load_byte[7];
         dc_d    = load_dc;
         cs_d    = 1'b0;
         sclk_d  = 1'b0;
         bit_d   = 3'd7;
         div_d   = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         state_q      <= POWER;
         src_q        <= SRC_INIT;
         cnt_q        <= 32'd0;
         bit_q        <= 3'd0;
         div_q        <= 8'd0;
         init_idx_q   <= 5'd0;
         win_idx_q    <= 3'd0;
         pix_q        <= '0;
         cmd_cnt_q    <= 8'd0;
         shift_q      <= 7'd0;
         sclk_q       <= 1'b1;
         sdin_q       <= 1'b0;
         cs_q         <= 1'b1;
         dc_q         <= 1'b1;
         prst_q       <= 1'b1;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         div_q        <= div_d;
         init_idx_q   <= init_idx_d;
         win_idx_q    <= win_idx_d;
         pix_q        <= pix_d;
         cmd_cnt_q    <= cmd_cnt_d;
         shift_q      <= shift_d;
         sclk_q       <= sclk_d;
         sdin_q       <= sdin_d;
         cs_q         <= cs_d;
         dc_q         <= dc_d;
         prst_q       <= prst_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign ioSclk       = sclk_q;
   assign ioSdin       = sdin_q;
   assign ioCs         = cs_q;
   assign ioDc         = dc_q;
   assign ioReset      = prst_q;
   assign pixelAddress = pix_q;
   assign frame_done   = frame_done_q;
   assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_ctrl.sv
`default_nettype none
// Scoreboard bench for oled_spi_ctrl: SPI byte stream, power timing, commands,
// asynchronous mid-frame reset and divided SPI clock.
module tb_oled_spi_ctrl;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_btn = 1'b0;
   logic          ioSclk, ioSdin, ioCs, ioDc, ioReset, cmd_ready, frame_done, busy;
   logic [AW-1:0] pixelAddress;
   logic [7:0]    pixelData = 8'h00;
   logic          cmd_valid = 1'b0;
   logic [7:0]    cmd_data = 8'h00;

   logic          s3_sclk, s3_sdin, s3_cs, s3_dc, s3_reset, s3_ready, s3_fd, s3_busy;
   logic [AW-1:0] s3_addr;

   int            errors = 0;
   int            checks = 0;
   logic [8:0]    exp_q[$];
   int            fd_count = 0;
   int            rdy_count = 0;
   int            rx_idx = 0;
   int            nbits = 0;
   logic [7:0]    rx_sh = 8'h00;
   logic          sclk_prev = 1'b1;

   always #5 clk = ~clk;

   oled_spi_ctrl #(
      .STARTUP_WAIT(32'd4), .CLK_DIV(1), .COLS(4), .PAGES(2), .CONTRAST(8'h7F), .CMD_MAX(2)
   ) dut (
      .clk(clk), .rst_btn(rst_btn), .ioSclk(ioSclk), .ioSdin(ioSdin), .ioCs(ioCs),
      .ioDc(ioDc), .ioReset(ioReset), .pixelAddress(pixelAddress), .pixelData(pixelData),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .frame_done(frame_done), .busy(busy)
   );

   oled_spi_ctrl #(
      .STARTUP_WAIT(32'd4), .CLK_DIV(3), .COLS(4), .PAGES(2), .CONTRAST(8'h7F), .CMD_MAX(2)
   ) dut3 (
      .clk(clk), .rst_btn(rst_btn), .ioSclk(s3_sclk), .ioSdin(s3_sdin), .ioCs(s3_cs),
      .ioDc(s3_dc), .ioReset(s3_reset), .pixelAddress(s3_addr), .pixelData(8'h00),
      .cmd_valid(1'b0), .cmd_data(8'h00), .cmd_ready(s3_ready),
      .frame_done(s3_fd), .busy(s3_busy)
   );

   // Framebuffer with one cycle of read latency.
   always @(posedge clk) pixelData <= 8'h10 + 8'(pixelAddress);

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         0: return 8'hAE;  1: return 8'h81;  2: return 8'h7F;  3: return 8'hA6;
         4: return 8'h20;  5: return 8'h00;  6: return 8'hC8;  7: return 8'h40;
         8: return 8'hA1;  9: return 8'hA8; 10: return 8'h0F; 11: return 8'hD3;
        12: return 8'h00; 13: return 8'hD5; 14: return 8'h80; 15: return 8'hD9;
        16: return 8'h22; 17: return 8'hDB; 18: return 8'h20; 19: return 8'h8D;
        20: return 8'h14; 21: return 8'hA4; 22: return 8'hAF;
        default: return 8'h00;
      endcase
   endfunction

   task automatic push_init();
      for (int i = 0; i < 23; i++) exp_q.push_back({1'b0, init_byte(i)});
   endtask

   task automatic push_window();
      exp_q.push_back(9'h021); exp_q.push_back(9'h000); exp_q.push_back(9'h003);
      exp_q.push_back(9'h022); exp_q.push_back(9'h000); exp_q.push_back(9'h001);
   endtask

   task automatic push_data(input int nbytes);
      for (int k = 0; k < nbytes; k++) exp_q.push_back({1'b1, 8'h10 + 8'(k)});
   endtask

   task automatic push_cmds();
      exp_q.push_back(9'h0A7); exp_q.push_back(9'h0A7);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_ioReset", ioReset, 1);
      check_eq("rst_ioCs", ioCs, 1);
      check_eq("rst_ioSclk", ioSclk, 1);
      check_eq("rst_ioSdin", ioSdin, 0);
      check_eq("rst_ioDc", ioDc, 1);
      check_eq("rst_addr", pixelAddress, 0);
      check_eq("rst_cmd_ready", cmd_ready, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_busy", busy, 1);
   endtask

   // Release reset between edges; cycle c is sampled 1 time unit after the c-th rising edge.
   task automatic power_up();
      @(negedge clk);
      rst_btn = 1'b1;
      #1;
      for (int c = 0; c <= 13; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         check_eq("pwr_ioReset", ioReset, (c < 4 || c >= 8) ? 1 : 0);
         if (c >= 12) check_eq("pwr_ioCs", ioCs, (c < 13) ? 1 : 0);
      end
      check_eq("pwr_addr", pixelAddress, 0);
   endtask

   // SPI monitor: bit captured on each ioSclk rise while selected.
   always @(negedge clk) begin : spi_mon
      logic [7:0] b;
      if (!rst_btn) begin
         nbits     = 0;
         rx_idx    = 0;
         sclk_prev = 1'b1;
      end else begin
         if (!sclk_prev && ioSclk && !ioCs) begin
            b     = {rx_sh[6:0], ioSdin};
            rx_sh = b;
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               if (rx_idx == 22) check_eq("busy_at_AF", busy, 1);
               if (rx_idx == 23) check_eq("busy_after_init", busy, 0);
               rx_idx++;
               check_eq("q_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check_eq("spi_byte", {ioDc, b}, exp_q.pop_front());
            end
         end
         sclk_prev = ioSclk;
      end
   end

   always @(negedge clk) begin
      if (frame_done) fd_count++;
      if (cmd_ready) rdy_count++;
   end

   initial begin : div3_meas
      int n, t0, t1, t2, t3;
      n = 0;
      while (rst_btn !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      while (s3_cs !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      t0 = n;
      while (s3_sclk !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      t1 = n;
      while (s3_sclk !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      t2 = n;
      while (s3_cs !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      while (s3_cs !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      t3 = n;
      check_eq("div3_low", t1 - t0, 3);
      check_eq("div3_high", t2 - t1, 3);
      check_eq("div3_period", t3 - t0, 50);
   end

   initial begin : main
      int n;
      rst_btn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();

      push_init(); push_window(); push_data(8); push_window(); push_data(8);
      power_up();

      n = 0;
      while (fd_count < 1 && n < 3000) begin @(negedge clk); n++; end
      check_eq("frame1_seen", fd_count >= 1, 1);
      repeat (5) @(negedge clk);
      cmd_data  = 8'hA7;
      cmd_valid = 1'b1;
      push_cmds(); push_window(); push_data(8); push_cmds(); push_window(); push_data(5);

      n = 0;
      while (rdy_count < 4 && n < 4000) begin @(negedge clk); n++; end
      check_eq("cmd_ready_count", rdy_count, 4);
      @(posedge clk);
      #1 cmd_valid = 1'b0;

      n = 0;
      while (!(fd_count >= 3 && pixelAddress == 3'd5 && ioCs == 1'b0) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check_eq("byte5_reached", n < 4000, 1);
      repeat (3) @(negedge clk);
      #2 rst_btn = 1'b0;
      #1;
      check_reset_outputs();
      check_eq("abort_q_drained", exp_q.size(), 0);
      check_eq("frame_done_count", fd_count, 3);
      check_eq("cmd_ready_total", rdy_count, 4);

      repeat (2) @(negedge clk);
      push_init(); push_window();
      power_up();
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
      check_eq("restart_drained", exp_q.size(), 0);
      check_eq("restart_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
